otter_fetch_stage: RTL and testbench
====================================

// Module: otter_fetch_stage
// PURPOSE
//   IF stage plus IF/ID pipeline register of the pipelined OTTER core.
//   Owns PC_F and drives the synchronous instruction memory (1-cycle read latency).
//   Presents instr/pc/pc+4 to Decode and consumes stall_F/stall_D from the hazard unit.
//   Also consumes the branch/jump redirect (pc_src_E, pc_target_E, flush_D) from Execute.
// PARAMETERS
//   RESET_VEC  32'h0000_0000  PC_F value while RST_N is low
//   NOP_INSTR  32'h0000_0013  instr_D value for a bubble (addi x0,x0,0)
// PORTS
//   CLK          in   1   core clock, rising edge
//   RST_N        in   1   asynchronous active-low reset
//   stall_F      in   1   hold PC_F
//   stall_D      in   1   hold IF/ID register
//   flush_D      in   1   squash IF/ID contents (taken branch/jump)
//   pc_src_E     in   1   redirect PC_F to pc_target_E
//   pc_target_E  in   32  redirect address; bits [1:0] ignored, forced to 2'b00
//   imem_addr    out  32  instruction memory address, = PC_F
//   imem_en      out  1   memory read enable
//   imem_rdata   in   32  memory data for the address presented last cycle
//   instr_D      out  32  instruction to Decode
//   pc_D         out  32  PC of instr_D
//   pc_plus4_D   out  32  pc_D + 4
//   valid_D      out  1   instr_D is a real instruction
// BEHAVIOUR
//   Reset (async assert, sync release): PC_F=RESET_VEC, pc_D=0, valid_D=0,
//     hold_valid=0, instr_hold=NOP_INSTR; imem_en=0 while RST_N=0, else 1.
//   PC_F next (priority): pc_src_E -> {pc_target_E[31:2],2'b00};
//     else stall_F -> hold; else PC_F+4. Add is mod 2^32 (FFFF_FFFC -> 0000_0000).
//   IF/ID next (priority): flush_D -> valid_D=0, hold_valid=0, pc_D unchanged;
//     else stall_D -> all IF/ID state holds; else pc_D<=PC_F, valid_D<=1.
//   Latency: instruction at PC_F appears on instr_D the cycle after PC_F is
//     presented on imem_addr (aligned with pc_D).
//   Stall hold: imem_rdata is not guaranteed stable during a stall. On the first
//     stall_D cycle (hold_valid=0, no flush), instr_hold<=imem_rdata, hold_valid<=1.
//     hold_valid clears on any cycle with stall_D=0 or flush_D=1.
//   instr_D = !valid_D ? NOP_INSTR : hold_valid ? instr_hold : imem_rdata.
//   pc_plus4_D = pc_D + 4, combinational, mod 2^32.
//   Simultaneous events:
//     flush_D with stall_D: flush wins; bubble inserted, hold dropped.
//     pc_src_E with stall_F: redirect wins.
//     flush_D without pc_src_E: legal; only IF/ID squashed.
//   Post-redirect: the cycle after a flush carries wrong-path rdata, masked by valid_D=0.
//     The target's instruction is valid_D=1 two cycles after the redirect edge.
//   Reset mid-stall/mid-flush: all state returns to reset values immediately.
//     First valid_D=1 is the 2nd rising edge after release, with pc_D=RESET_VEC.
// TESTING
//   Reset release, no stalls, imem[i]=i*16 -> pc_D=0,4,8.. consecutive;
//     instr_D matches imem; valid_D=1 from 2nd edge.
//   stall_F=stall_D=1 for 3 cycles at pc_D=8, imem_rdata randomized meanwhile
//     -> pc_D=8, instr_D=imem[8] throughout; pc_D=C on the cycle after release.
//   pc_src_E=1, flush_D=1, pc_target_E=32'h0000_0103 at pc_D=10
//     -> next cycle valid_D=0 and instr_D=0000_0013;
//     -> following cycle pc_D=0000_0100, valid_D=1.
//   flush_D, pc_src_E, stall_F, stall_D all 1, target 0x40
//     -> bubble; then pc_D=0x40, no stale hold data.
//   PC_F=FFFF_FFFC, no stall -> imem_addr wraps to 0000_0000; pc_plus4_D=0.
//   RST_N low mid-stall (hold_valid=1) -> immediately valid_D=0, PC_F=RESET_VEC;
//     after release, normal fetch from RESET_VEC.

Source files
------------

// File: rtl/otter_fetch_stage.sv
// IF stage and IF/ID pipeline register of the pipelined OTTER core.
// Owns PC_F, drives a 1-cycle-latency synchronous instruction memory and feeds Decode.
module otter_fetch_stage #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall_f,
  input  logic        i_stall_d,
  input  logic        i_flush_d,
  input  logic        i_pc_src_e,
  input  logic [31:0] i_pc_target_e,
  output logic [31:0] o_imem_addr,
  output logic        o_imem_en,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_instr_d,
  output logic [31:0] o_pc_d,
  output logic [31:0] o_pc_plus4_d,
  output logic        o_valid_d
);

  logic        r_rst_sync;
  logic [31:0] r_pc_f;
  logic [31:0] r_pc_d;
  logic        r_valid_d;
  logic        r_hold_valid;
  logic [31:0] r_instr_hold;
  logic [31:0] w_pc_f_next;
  logic        w_unused_target_bits;

  assign w_unused_target_bits = &{1'b0, i_pc_target_e[1:0]};

  // Release synchronizer: pipeline state stays at reset values for one edge after release.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_sync <= 1'b1;
    end
  end

  // Next-PC selection: redirect beats stall beats sequential increment.
  always_comb begin
    w_pc_f_next = r_pc_f;
    if (i_pc_src_e) begin
      w_pc_f_next = {i_pc_target_e[31:2], 2'b00};
    end else if (i_stall_f) begin
      w_pc_f_next = r_pc_f;
    end else begin
      w_pc_f_next = r_pc_f + 32'd4;
    end
  end

  // PC_F register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc_f <= RESET_VEC;
    end else if (!r_rst_sync) begin
      r_pc_f <= RESET_VEC;
    end else begin
      r_pc_f <= w_pc_f_next;
    end
  end

  // IF/ID register; the first stalled cycle latches rdata because memory output may drift.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc_d       <= 32'h0000_0000;
      r_valid_d    <= 1'b0;
      r_hold_valid <= 1'b0;
      r_instr_hold <= NOP_INSTR;
    end else if (!r_rst_sync) begin
      r_pc_d       <= 32'h0000_0000;
      r_valid_d    <= 1'b0;
      r_hold_valid <= 1'b0;
      r_instr_hold <= NOP_INSTR;
    end else if (i_flush_d) begin
      r_valid_d    <= 1'b0;
      r_hold_valid <= 1'b0;
    end else if (i_stall_d) begin
      if (!r_hold_valid) begin
        r_instr_hold <= i_imem_rdata;
        r_hold_valid <= 1'b1;
      end else begin
        r_hold_valid <= 1'b1;
      end
    end else begin
      r_pc_d       <= r_pc_f;
      r_valid_d    <= 1'b1;
      r_hold_valid <= 1'b0;
    end
  end

  // Decode-facing instruction select: bubble, held word, or live memory data.
  always_comb begin
    o_instr_d = i_imem_rdata;
    if (!r_valid_d) begin
      o_instr_d = NOP_INSTR;
    end else if (r_hold_valid) begin
      o_instr_d = r_instr_hold;
    end else begin
      o_instr_d = i_imem_rdata;
    end
  end

  assign o_imem_addr  = r_pc_f;
  assign o_imem_en    = i_rst_n;
  assign o_pc_d       = r_pc_d;
  assign o_pc_plus4_d = r_pc_d + 32'd4;
  assign o_valid_d    = r_valid_d;

endmodule

// File: tb/tb_otter_fetch_stage.sv
// Directed bench for otter_fetch_stage with a synchronous memory model where
// the word at byte address A is (A/4)*16, i.e. A<<2.
module tb_otter_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        stall_f;
  logic        stall_d;
  logic        flush_d;
  logic        pc_src_e;
  logic [31:0] pc_target_e;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_rdata;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic        rnd_mode;

  int n_cmp;
  int n_bad;

  otter_fetch_stage dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_stall_f     (stall_f),
    .i_stall_d     (stall_d),
    .i_flush_d     (flush_d),
    .i_pc_src_e    (pc_src_e),
    .i_pc_target_e (pc_target_e),
    .o_imem_addr   (imem_addr),
    .o_imem_en     (imem_en),
    .i_imem_rdata  (imem_rdata),
    .o_instr_d     (instr_d),
    .o_pc_d        (pc_d),
    .o_pc_plus4_d  (pc_plus4_d),
    .o_valid_d     (valid_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory; returns junk while rnd_mode is set.
  always @(posedge clk) begin
    if (imem_en) begin
      if (rnd_mode) imem_rdata <= $urandom;
      else          imem_rdata <= imem_addr << 2;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0; pc_src_e = 1'b0;
    pc_target_e = 32'h0000_0000;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rnd_mode = 1'b0; imem_rdata = 32'h0000_0000;
    rst_n = 1'b0;
    clr();
    repeat (3) step();

    chk("rst_valid", {31'd0, valid_d}, 32'd0);
    chk("rst_en",    {31'd0, imem_en}, 32'd0);
    chk("rst_addr",  imem_addr, 32'h0000_0000);
    chk("rst_instr", instr_d, NOP);
    chk("rst_pcd",   pc_d, 32'h0000_0000);
    chk("rst_pcp4",  pc_plus4_d, 32'h0000_0004);

    rst_n = 1'b1;
    #1;
    chk("rel_en", {31'd0, imem_en}, 32'd1);
    step();
    chk("edge1_valid", {31'd0, valid_d}, 32'd0);
    step();
    chk("edge2_valid", {31'd0, valid_d}, 32'd1);
    chk("edge2_pcd",   pc_d, 32'h0000_0000);
    chk("edge2_instr", instr_d, 32'h0000_0000);
    step();
    chk("seq4_pcd",   pc_d, 32'h0000_0004);
    chk("seq4_instr", instr_d, 32'h0000_0010);
    chk("seq4_pcp4",  pc_plus4_d, 32'h0000_0008);
    step();
    chk("seq8_pcd",   pc_d, 32'h0000_0008);
    chk("seq8_instr", instr_d, 32'h0000_0020);
    chk("seq8_addr",  imem_addr, 32'h0000_000C);

    // Three-cycle stall with junk on the memory bus.
    stall_f = 1'b1; stall_d = 1'b1; rnd_mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pcd",   pc_d, 32'h0000_0008);
      chk("stall_instr", instr_d, 32'h0000_0020);
      chk("stall_addr",  imem_addr, 32'h0000_000C);
    end
    clr(); rnd_mode = 1'b0;
    step();
    chk("unstall_pcd",   pc_d, 32'h0000_000C);
    chk("unstall_instr", instr_d, 32'h0000_0030);
    step();
    chk("pc10_pcd", pc_d, 32'h0000_0010);

    // Taken redirect to a misaligned target.
    pc_src_e = 1'b1; flush_d = 1'b1; pc_target_e = 32'h0000_0103;
    step();
    chk("flush_valid", {31'd0, valid_d}, 32'd0);
    chk("flush_instr", instr_d, NOP);
    chk("flush_addr",  imem_addr, 32'h0000_0100);
    chk("flush_pcd",   pc_d, 32'h0000_0010);
    clr();
    step();
    chk("tgt_pcd",   pc_d, 32'h0000_0100);
    chk("tgt_valid", {31'd0, valid_d}, 32'd1);
    chk("tgt_instr", instr_d, 32'h0000_0400);

    // Establish a held word, then all four controls together.
    stall_f = 1'b1; stall_d = 1'b1; rnd_mode = 1'b1;
    step();
    chk("hold_instr", instr_d, 32'h0000_0400);
    flush_d = 1'b1; pc_src_e = 1'b1; pc_target_e = 32'h0000_0040;
    step();
    chk("all_valid", {31'd0, valid_d}, 32'd0);
    chk("all_instr", instr_d, NOP);
    chk("all_addr",  imem_addr, 32'h0000_0040);
    clr(); rnd_mode = 1'b0;
    step();
    chk("all_pcd",   pc_d, 32'h0000_0040);
    chk("all_instr2", instr_d, 32'h0000_0100);
    chk("all_valid2", {31'd0, valid_d}, 32'd1);

    // PC wrap at the top of the address space.
    pc_src_e = 1'b1; flush_d = 1'b1; pc_target_e = 32'hFFFF_FFFC;
    step();
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    clr();
    step();
    chk("wrap_pcd",   pc_d, 32'hFFFF_FFFC);
    chk("wrap_addr",  imem_addr, 32'h0000_0000);
    chk("wrap_pcp4",  pc_plus4_d, 32'h0000_0000);
    chk("wrap_instr", instr_d, 32'hFFFF_FFF0);

    // Reset asserted while a stall holds an instruction.
    stall_f = 1'b1; stall_d = 1'b1; rnd_mode = 1'b1;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", {31'd0, valid_d}, 32'd0);
    chk("mrst_addr",  imem_addr, 32'h0000_0000);
    chk("mrst_instr", instr_d, NOP);
    chk("mrst_pcd",   pc_d, 32'h0000_0000);
    clr(); rnd_mode = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("mrel1_valid", {31'd0, valid_d}, 32'd0);
    step();
    chk("mrel2_valid", {31'd0, valid_d}, 32'd1);
    chk("mrel2_pcd",   pc_d, 32'h0000_0000);
    chk("mrel2_instr", instr_d, 32'h0000_0000);
    step();
    chk("mrel3_pcd",   pc_d, 32'h0000_0004);
    chk("mrel3_instr", instr_d, 32'h0000_0010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
